arf132b192e1r1w0cbbehcaa4acw_rd_ctrl: RTL and testbench

Read-port controller for the 132-entry x 192-bit 1R1W register file array. It accepts read requests over a valid/ready handshake and drives the array read port. It captures the array's 1-cycle read data into a credit-protected response FIFO and returns responses over a valid/ready handshake. It is the consumer side of the array: the write-port staging flops feed the array, and this block drains it.

---
 rtl/arf132b192e1r1w0cbbehcaa4acw_rd_ctrl.sv | 149 ++++++++++++++
 tb/tb_arf132b192e1r1w0cbbehcaa4acw_rd_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arf132b192e1r1w0cbbehcaa4acw_rd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arf132b192e1r1w0cbbehcaa4acw_rd_ctrl: read-port controller, credit FIFO  |
// | Optional: ARF132B192E1R1W0CBBEHCAA4ACW_RD_WR_BYPASS_EN (same-cycle fwd)  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module arf132b192e1r1w0cbbehcaa4acw_rd_ctrl #(
  parameter int ENTRIES   = 132,
  parameter int DWIDTH    = 192,
  parameter int AWIDTH    = 8,
  parameter int RSP_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req_vld,
  output logic              rd_req_rdy,
  input  logic [AWIDTH-1:0] rd_req_addr,
  output logic              arr_rd_en,
  output logic [AWIDTH-1:0] arr_rd_addr,
  input  logic [DWIDTH-1:0] arr_rd_data,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              rd_rsp_vld,
  input  logic              rd_rsp_rdy,
  output logic [DWIDTH-1:0] rd_rsp_data,
  output logic              rd_rsp_err
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CW:0]     c_depth    = (CW + 1)'(RSP_DEPTH);
  localparam logic [AWIDTH:0] c_entries  = (AWIDTH + 1)'(ENTRIES);
  localparam logic [PW-1:0]   c_last_ptr = PW'(RSP_DEPTH - 1);

  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic              infl_q, infl_d;
  logic              infl_err_q, infl_err_d;
  logic [DWIDTH-1:0] mem_q [RSP_DEPTH];
  logic [DWIDTH-1:0] mem_d [RSP_DEPTH];
  logic              err_q [RSP_DEPTH];
  logic              err_d [RSP_DEPTH];

  logic [CW:0]       occupancy;
  logic              accept;
  logic              in_range;
  logic              push;
  logic              pop;
  logic [DWIDTH-1:0] push_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == c_last_ptr) ? '0 : p + 1'b1;
  endfunction

  // Credits count both queued and in-flight responses, so a push never finds the FIFO full.
  assign occupancy   = {1'b0, count_q} + {{CW{1'b0}}, infl_q};
  assign rd_req_rdy  = ~rst & (occupancy < c_depth);
  assign accept      = rd_req_vld & rd_req_rdy;
  assign in_range    = ({1'b0, rd_req_addr} < c_entries);
  assign arr_rd_en   = accept & in_range;
  assign arr_rd_addr = rd_req_addr;

  assign rd_rsp_vld  = (count_q != '0);
  assign rd_rsp_data = rd_rsp_vld ? mem_q[rptr_q] : '0;
  assign rd_rsp_err  = rd_rsp_vld ? err_q[rptr_q] : 1'b0;

  assign push = infl_q;
  assign pop  = rd_rsp_vld & rd_rsp_rdy;

`ifdef ARF132B192E1R1W0CBBEHCAA4ACW_RD_WR_BYPASS_EN
  logic              byp_hit_q, byp_hit_d;
  logic [DWIDTH-1:0] byp_data_q, byp_data_d;

  always_comb begin
    byp_hit_d  = arr_rd_en & wr_en & (wr_addr == rd_req_addr);
    byp_data_d = wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_hit_q  <= byp_hit_d;
      byp_data_q <= byp_data_d;
    end
  end

  always_comb begin
    push_data = '0;
    if (!infl_err_q) push_data = byp_hit_q ? byp_data_q : arr_rd_data;
  end
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};

  always_comb begin
    push_data = '0;
    if (!infl_err_q) push_data = arr_rd_data;
  end
`endif

  always_comb begin
    mem_d      = mem_q;
    err_d      = err_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    infl_d     = accept;
    infl_err_d = accept & ~in_range;
    if (push) begin
      mem_d[wptr_q] = push_data;
      err_d[wptr_q] = infl_err_q;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (pop) rptr_d = ptr_inc(rptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      infl_q     <= 1'b0;
      infl_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      infl_q     <= infl_d;
      infl_err_q <= infl_err_d;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    err_q <= err_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_arf132b192e1r1w0cbbehcaa4acw_rd_ctrl.sv
`default_nettype none
// Scoreboard bench for arf132b192e1r1w0cbbehcaa4acw_rd_ctrl with an array model and random traffic.
module tb_arf132b192e1r1w0cbbehcaa4acw_rd_ctrl;
  localparam int NE = 132;
  localparam int DW = 192;
  localparam int AW = 8;
  localparam int DEPTH = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req_vld;
  logic          rd_req_rdy;
  logic [AW-1:0] rd_req_addr;
  logic          arr_rd_en;
  logic [AW-1:0] arr_rd_addr;
  logic [DW-1:0] arr_rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_rsp_vld;
  logic          rd_rsp_rdy;
  logic [DW-1:0] rd_rsp_data;
  logic          rd_rsp_err;

  arf132b192e1r1w0cbbehcaa4acw_rd_ctrl #(
    .ENTRIES(NE), .DWIDTH(DW), .AWIDTH(AW), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy), .rd_req_addr(rd_req_addr),
    .arr_rd_en(arr_rd_en), .arr_rd_addr(arr_rd_addr), .arr_rd_data(arr_rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_rsp_vld(rd_rsp_vld), .rd_rsp_rdy(rd_rsp_rdy),
    .rd_rsp_data(rd_rsp_data), .rd_rsp_err(rd_rsp_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_acc = 0;
  int last_pop = -10;
  bit rst_prev = 1'b0;

  typedef struct {
    logic [DW-1:0] d;
    logic          e;
    int            acc;
  } rsp_t;
  rsp_t q[$];

  logic [DW-1:0] mem [NE];

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Array model: registered read returning pre-write data; junk when not enabled.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    arr_rd_data <= arr_rd_en ? mem[arr_rd_addr] : rnd_data();
    if (wr_en && wr_addr < NE) mem[wr_addr] <= wr_data;
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_rdy", {191'd0, rd_req_rdy}, '0);
      chk("rst_arr_rd_en", {191'd0, arr_rd_en}, '0);
      if (rst_prev) begin
        chk("rst_rsp_vld", {191'd0, rd_rsp_vld}, '0);
        chk("rst_rsp_data", rd_rsp_data, '0);
        chk("rst_rsp_err", {191'd0, rd_rsp_err}, '0);
      end
      q.delete();
      rst_prev = 1'b1;
    end else begin
      logic exp_vld;
      int vis;
      if (rst_prev) begin
        chk("post_rst_data", rd_rsp_data, '0);
        chk("post_rst_err", {191'd0, rd_rsp_err}, '0);
      end
      chk("req_rdy", {191'd0, rd_req_rdy}, {191'd0, (q.size() < DEPTH)});
      exp_vld = 1'b0;
      if (q.size() > 0) begin
        vis = (q[0].acc + 2 > last_pop + 1) ? q[0].acc + 2 : last_pop + 1;
        exp_vld = (cyc >= vis);
      end
      chk("rsp_vld", {191'd0, rd_rsp_vld}, {191'd0, exp_vld});
      if (rd_rsp_vld && exp_vld) begin
        chk("rsp_data", rd_rsp_data, q[0].d);
        chk("rsp_err", {191'd0, rd_rsp_err}, {191'd0, q[0].e});
        if (rd_rsp_rdy) begin
          void'(q.pop_front());
          last_pop = cyc;
        end
      end
      if (rd_req_vld && rd_req_rdy) begin
        rsp_t r;
        bit inr;
        inr = (rd_req_addr < NE);
        chk("arr_rd_en", {191'd0, arr_rd_en}, {191'd0, inr});
        if (inr) chk("arr_rd_addr", {184'd0, arr_rd_addr}, {184'd0, rd_req_addr});
        r.acc = cyc;
        r.e = !inr;
        if (!inr) r.d = '0;
        else begin
          r.d = mem[rd_req_addr];
`ifdef ARF132B192E1R1W0CBBEHCAA4ACW_RD_WR_BYPASS_EN
          if (wr_en && wr_addr == rd_req_addr) r.d = wr_data;
`endif
        end
        q.push_back(r);
        n_acc++;
        chk("no_overfill", {191'd0, (q.size() > DEPTH)}, '0);
      end else begin
        chk("arr_rd_en_idle", {191'd0, arr_rd_en}, '0);
      end
      rst_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [AW-1:0] a);
    bit done;
    done = 1'b0;
    rd_req_vld = 1'b1;
    rd_req_addr = a;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = rd_req_rdy;
      tick();
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL send_timeout: addr %0d not accepted, want accept within 50 cycles", a);
    end
    rd_req_vld = 1'b0;
  endtask

  initial begin
    int a0;
    rst = 1'b1;
    rd_req_vld = 1'b0;
    rd_req_addr = '0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_rsp_rdy = 1'b1;
    for (int i = 0; i < NE; i++) mem[i] = rnd_data();
    mem[5] = {24{8'hA5}};
    mem[7] = 192'hFFFF;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // single read
    send(8'd5);
    repeat (4) tick();

    // streaming 0..131
    for (int i = 0; i < NE; i++) send(AW'(i));
    repeat (4) tick();

    // backpressure: only DEPTH accepted
    rd_rsp_rdy = 1'b0;
    a0 = n_acc;
    for (int i = 0; i < 8; i++) begin
      rd_req_vld = 1'b1;
      rd_req_addr = AW'(10 + i);
      tick();
    end
    rd_req_vld = 1'b0;
    chk("bp_accepts", DW'(n_acc - a0), DW'(DEPTH));
    rd_rsp_rdy = 1'b1;
    repeat (6) tick();

    // out of range
    send(8'd132);
    send(8'd255);
    repeat (4) tick();

    // same-cycle write/read collision
    wr_en = 1'b1;
    wr_addr = 8'd7;
    wr_data = 192'h1234;
    send(8'd7);
    wr_en = 1'b0;
    repeat (4) tick();

    // reset with two queued and one in flight
    rd_rsp_rdy = 1'b0;
    send(8'd20);
    send(8'd21);
    send(8'd22);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_rsp_rdy = 1'b1;
    repeat (3) tick();
    send(8'd5);
    repeat (4) tick();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rd_req_vld = ($urandom_range(0, 3) != 0);
      rd_req_addr = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(132, 255))
                                                 : AW'($urandom_range(0, NE - 1));
      rd_rsp_rdy = ($urandom_range(0, 2) != 0);
      wr_en = $urandom_range(0, 1);
      wr_addr = $urandom_range(0, 1) ? ((rd_req_addr < NE) ? rd_req_addr : 8'd3)
                                     : AW'($urandom_range(0, NE - 1));
      wr_data = rnd_data();
      tick();
    end
    rd_req_vld = 1'b0;
    wr_en = 1'b0;
    rd_rsp_rdy = 1'b1;
    repeat (10) tick();
    chk("drained", DW'(q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
